// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes agreed with the ALU control decoder,
// FSM state encoding, shift-kind encoding and default widths.
package alu_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_SHAMT_WIDTH = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [1:0] SHK_SLL = 2'd0;
  localparam logic [1:0] SHK_SRL = 2'd1;
  localparam logic [1:0] SHK_SRA = 2'd2;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
  endfunction

  function automatic logic [1:0] shift_kind(input logic [2:0] op);
    logic [1:0] k;
    case (op)
      ALU_SRA: k = SHK_SRA;
      ALU_SRL: k = SHK_SRL;
      default: k = SHK_SLL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shifter (sll/srl/sra) used by the iterative shift state.
// Zero latency; no flow control.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [1:0]       kind_i,
  output logic [WIDTH-1:0] shifted_o
);

  always_comb begin
    case (kind_i)
      SHK_SLL: shifted_o = {value_i[WIDTH-2:0], 1'b0};
      SHK_SRL: shifted_o = {1'b0, value_i[WIDTH-1:1]};
      SHK_SRA: shifted_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
      default: shifted_o = value_i;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execution ALU: single-cycle add/sub/logic, shifts one bit per cycle (done after 1+shamt cycles).
// Backpressure: start_i is ignored while busy_o is high; the requester must hold off and retry.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            ALUCtrl_i,
  input  logic [DATA_WIDTH-1:0] src1_i,
  input  logic [DATA_WIDTH-1:0] src2_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]             kind_q, kind_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   done_q, done_d;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic [DATA_WIDTH-1:0]  step_res;

  assign shamt = src2_i[SHAMT_WIDTH-1:0];

  // Shift ops only reach this path with shamt 0, which passes src1 through.
  always_comb begin
    case (ALUCtrl_i)
      ALU_ADD: alu_res = src1_i + src2_i;
      ALU_SUB: alu_res = src1_i - src2_i;
      ALU_AND: alu_res = src1_i & src2_i;
      ALU_OR:  alu_res = src1_i | src2_i;
      ALU_XOR: alu_res = src1_i ^ src2_i;
      default: alu_res = src1_i;
    endcase
  end

  alu_shift_step #(.WIDTH(DATA_WIDTH)) u_shift_step (
    .value_i  (work_q),
    .kind_i   (kind_q),
    .shifted_o(step_res)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_shift_op(ALUCtrl_i) && (shamt != '0)) begin
            work_d  = src1_i;
            cnt_d   = shamt;
            kind_d  = shift_kind(ALUCtrl_i);
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      default: begin
        work_d = step_res;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = step_res;
          zero_d   = (step_res == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      kind_q   <= SHK_SLL;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == ST_SHIFT);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: vector table plus hand-written multi-cycle sequences.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  multicycle_alu dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .ALUCtrl_i(op),
    .src1_i   (src1),
    .src2_i   (src2),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .zero_o   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge and measure cycles until done_o.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input int elat);
    int cyc;
    int busy_bad;
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    start = 1'b0; op = ALU_XOR; src1 = ~a; src2 = ~b;
    cyc = 1;
    busy_bad = 0;
    while (!done && cyc < 100) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " latency"}, 32'(cyc), 32'(elat));
    chk({name, " busy during shift"}, 32'(busy_bad), 32'd0);
    chk({name, " busy at done"}, 32'(busy), 32'd0);
    chk({name, " result"}, result, er);
    chk({name, " zero"}, 32'(zero), 32'(ez));
    @(negedge clk);
    chk({name, " done pulse width"}, 32'(done), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst && done && busy) begin
      checks++;
      errors++;
      $display("FAIL done_and_busy: got done=1 busy=1 expected never both");
    end
  end

  initial begin
    int seen;
    vecs[0] = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
    vecs[1] = '{ALU_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1};
    vecs[2] = '{ALU_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1};
    vecs[3] = '{ALU_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1};
    vecs[4] = '{ALU_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5};
    vecs[5] = '{ALU_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 5};
    vecs[6] = '{ALU_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};
    vecs[7] = '{ALU_SLL, 32'hA5A5_A5A5, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 1};
    vecs[8] = '{ALU_SRA, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0, 2};
    vecs[9] = '{ALU_SRL, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 2};

    repeat (2) @(negedge clk);
    chk("reset result", result, 32'h0);
    chk("reset zero", 32'(zero), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].z, vecs[i].lat);

    // Back-to-back single-cycle ops
    @(negedge clk);
    start = 1'b1; op = ALU_AND; src1 = 32'hF0F0_F0F0; src2 = 32'hFF00_FF00;
    @(negedge clk);
    chk("b2b and done", 32'(done), 32'd1);
    chk("b2b and result", result, 32'hF000_F000);
    op = ALU_OR;
    @(negedge clk);
    chk("b2b or done", 32'(done), 32'd1);
    chk("b2b or result", result, 32'hFFF0_FFF0);
    op = ALU_XOR;
    @(negedge clk);
    chk("b2b xor done", 32'(done), 32'd1);
    chk("b2b xor result", result, 32'h0FF0_0FF0);
    chk("b2b xor zero", 32'(zero), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("b2b idle done", 32'(done), 32'd0);

    // Asynchronous reset between edges while idle
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst result", result, 32'h0);
    chk("async rst zero", 32'(zero), 32'd1);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("pre-ignore add", ALU_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1);

    // start during busy is dropped
    @(negedge clk);
    start = 1'b1; op = ALU_SRA; src1 = 32'h8000_0000; src2 = 32'h0000_0004;
    @(negedge clk);
    chk("ign busy", 32'(busy), 32'd1);
    op = ALU_ADD; src1 = 32'h0000_0001; src2 = 32'h0000_0001;
    @(negedge clk);
    chk("ign result held", result, 32'h0000_0030);
    chk("ign no done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("ign result held2", result, 32'h0000_0030);
    @(negedge clk);
    chk("ign still busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign done at N+5", 32'(done), 32'd1);
    chk("ign shift result", result, 32'hF800_0000);
    @(negedge clk);
    chk("ign no extra done", 32'(done), 32'd0);
    chk("ign not restarted", 32'(busy), 32'd0);

    // Reset mid-shift aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = ALU_SLL; src1 = 32'h0000_0001; src2 = 32'h0000_001F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midshift busy before rst", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midshift rst busy", 32'(busy), 32'd0);
    chk("midshift rst result", result, 32'h0);
    chk("midshift rst zero", 32'(zero), 32'd1);
    chk("midshift rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midshift no late done", 32'(seen), 32'd0);
    chk("midshift result stays", result, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
